// File: rtl/alu_operand_shifter.sv
// Serial operand/result buffer between byte-wide bus logic and the bit-serial ALU.
// An operand is shifted out NSHIFT bits per active cycle; ALU output bits are collected into a result word.
module alu_operand_shifter #(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*REG_BITS-1:0] in_data,
    input  logic                  in_pair,
    input  logic                  shift_en,
    input  logic                  alu_op_done,
    output logic [NSHIFT-1:0]     shift_out,
    input  logic [NSHIFT-1:0]     alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*REG_BITS-1:0] out_data,
    output logic                  busy
);
    localparam int W     = 2 * REG_BITS;
    localparam int NSLOT = W / NSHIFT;
    localparam int CW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [CW-1:0] LAST_PAIR   = CW'(NSLOT - 1);
    localparam logic [CW-1:0] LAST_SINGLE = CW'(REG_BITS / NSHIFT - 1);

    typedef enum logic [1:0] {IDLE, LOADED, SHIFTING, RESULT} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [W-1:0]    opnd, opnd_nx;
    logic [W-1:0]    res, res_nx;
    logic            pair, pair_nx;
    logic [CW-1:0]   last;

    assign last = pair ? LAST_PAIR : LAST_SINGLE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            opnd  <= '0;
            res   <= '0;
            pair  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            opnd  <= opnd_nx;
            res   <= res_nx;
            pair  <= pair_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        opnd_nx   = opnd;
        res_nx    = res;
        pair_nx   = pair;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        shift_out = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opnd_nx  = in_pair ? in_data : {{REG_BITS{1'b0}}, in_data[REG_BITS-1:0]};
                    pair_nx  = in_pair;
                    res_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = LOADED;
                end
            end
            LOADED, SHIFTING: begin
                shift_out = opnd[cnt*NSHIFT +: NSHIFT];
                // shift_en low is a stall: nothing consumed, nothing captured
                if (shift_en) begin
                    res_nx[cnt*NSHIFT +: NSHIFT] = alu_result;
                    if (alu_op_done || cnt == last) begin
                        cnt_nx   = '0;
                        state_nx = RESULT;
                    end else begin
                        cnt_nx   = cnt + 1'b1;
                        state_nx = SHIFTING;
                    end
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                out_data  = res;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_operand_shifter.sv
// Randomized self-checking bench for alu_operand_shifter against a transaction-level model.
module tb_alu_operand_shifter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_pair = 1'b0;
    logic        shift_en = 1'b0;
    logic        alu_op_done = 1'b0;
    logic [1:0]  shift_out;
    logic [1:0]  alu_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    alu_operand_shifter #(.REG_BITS(8), .NSHIFT(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_pair(in_pair), .shift_en(shift_en), .alu_op_done(alu_op_done),
        .shift_out(shift_out), .alu_result(alu_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 1);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".shift_out"}, 32'(shift_out), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    // stall_pct < 0 means shift_en alternates 1,0,1,0...
    // rmode: 0 = ALU loops operand back, 1 = fixed value, 2 = random
    task automatic run_txn(input logic [15:0] d, input bit pair, input int done_at,
                           input int stall_pct, input int rmode, input logic [1:0] fixed,
                           input int hold);
        logic [15:0] exp_op, exp_res;
        logic [1:0]  slot, ar;
        int          nslots, stop, k, cyc;
        bit          en;
        exp_op  = pair ? d : {8'h00, d[7:0]};
        nslots  = pair ? 8 : 4;
        stop    = (done_at >= 0 && done_at < nslots - 1) ? done_at : nslots - 1;
        exp_res = '0;
        chk("pre.in_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_data = d; in_pair = pair;
        tick();
        in_valid = 1'b0; in_data = 16'($urandom); in_pair = 1'($urandom);
        k = 0; cyc = 0;
        while (k <= stop) begin
            slot = 2'((exp_op >> (2 * k)) & 16'h3);
            chk("shift.shift_out", 32'(shift_out), 32'(slot));
            chk("shift.busy", 32'(busy), 1);
            chk("shift.in_ready", 32'(in_ready), 0);
            chk("shift.out_valid", 32'(out_valid), 0);
            en = (stall_pct < 0) ? (cyc % 2 == 0) : (int'($urandom_range(99)) >= stall_pct);
            ar = (rmode == 0) ? slot : (rmode == 1) ? fixed : 2'($urandom);
            shift_en = en; alu_result = ar;
            alu_op_done = en ? (k == done_at) : 1'($urandom);
            tick();
            if (en) begin
                exp_res = exp_res | (16'(ar) << (2 * k));
                k++;
            end
            cyc++;
            if (cyc > 200) begin
                chk("shift.timeout", 32'(cyc), 200);
                k = stop + 1;
            end
        end
        shift_en = 1'b0; alu_op_done = 1'b0;
        for (int h = 0; h < hold; h++) begin
            chk("hold.out_valid", 32'(out_valid), 1);
            chk("hold.out_data", 32'(out_data), 32'(exp_res));
            chk("hold.in_ready", 32'(in_ready), 0);
            in_valid = 1'($urandom); shift_en = 1'($urandom); alu_op_done = 1'($urandom);
            tick();
        end
        in_valid = 1'b0; shift_en = 1'b0; alu_op_done = 1'b0;
        chk("res.out_valid", 32'(out_valid), 1);
        chk("res.out_data", 32'(out_data), 32'(exp_res));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle("post");
        // shift_en in IDLE must not start anything
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        chk_idle("idle_shift_en");
    endtask

    initial begin
        tick();
        chk("rst.out_data", 32'(out_data), 0);
        chk_idle("rst");
        reset_n = 1'b1;
        tick();

        run_txn(16'hA5C3, 1'b1, 7, 0, 0, 2'b00, 0);      // 16-bit pass-through
        run_txn(16'h12F0, 1'b0, -1, 0, 1, 2'b01, 0);     // 8-bit, result 0x0055
        run_txn(16'h1234, 1'b1, -1, -1, 0, 2'b00, 1);    // alternating stall
        run_txn(16'hBEEF, 1'b1, 1, 0, 1, 2'b11, 0);      // early done -> 0x000F
        run_txn(16'h5A5A, 1'b0, -1, 0, 2, 2'b00, 5);     // downstream back-pressure

        // reset in the middle of a shift sequence
        in_valid = 1'b1; in_data = 16'hFFFF; in_pair = 1'b1;
        tick();
        in_valid = 1'b0;
        shift_en = 1'b1; alu_result = 2'b11;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; shift_en = 1'b0;
        chk("midrst.out_data", 32'(out_data), 0);
        chk_idle("midrst");
        tick();

        for (int t = 0; t < 30; t++) begin
            bit pr;
            int da;
            pr = 1'($urandom);
            da = ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1;
            run_txn(16'($urandom), pr, da, 30, 2, 2'b00, int'($urandom_range(3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
